// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage: one outstanding req/gnt/rvalid
// fetch at a time, with the result presented to decode over a valid/ready handshake.
module pc_fetch_unit #(
    parameter int              WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pc_sel,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] trap_vector,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             id_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic             kill;
    logic             req;
    logic             redirect;
    logic [WIDTH-1:0] target;

    // Redirect targets are always word aligned; the low two bits are dropped.
    function automatic logic [WIDTH-1:0] select_target(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] branch_addr,
        input logic [WIDTH-1:0] jump_addr,
        input logic [WIDTH-1:0] trap_addr
    );
        logic [WIDTH-1:0] result;
        case (sel)
            2'b01:   result = branch_addr;
            2'b10:   result = jump_addr;
            2'b11:   result = trap_addr;
            default: result = '0;
        endcase
        result[1:0] = 2'b00;
        return result;
    endfunction

    assign redirect  = (pc_sel != 2'b00);
    assign target    = select_target(pc_sel, branch_target, jump_target, trap_vector);
    assign imem_addr = pc;
    assign imem_req  = req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_VECTOR;
            kill        <= 1'b0;
            req         <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    req   <= 1'b1;
                end
                S_REQ: begin
                    if (redirect) pc <= target;
                    if (imem_gnt) begin
                        // A redirect in the grant cycle orphans the response now in flight.
                        kill  <= redirect;
                        state <= S_WAIT;
                        req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect) begin
                            kill  <= 1'b0;
                            if (redirect) pc <= target;
                            state <= S_REQ;
                            req   <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc + WIDTH'(4);
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (redirect) begin
                        pc   <= target;
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Redirect wins over id_ready: the held instruction is flushed.
                    if (redirect) begin
                        pc          <= target;
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                        req         <= 1'b1;
                    end else if (id_ready) begin
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                        req         <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: granted fetches push the expected (pc, instr) pair
// onto a queue that is popped when decode sees instr_valid.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target, jump_target, trap_vector;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        id_ready;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pc_fetch_unit #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel),
        .branch_target(branch_target), .jump_target(jump_target), .trap_vector(trap_vector),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Grant at addr, return data one cycle later, accept in HOLD.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            failures++;
            $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle_valid: instr_valid=%b, expected 0", instr_valid);
        end
        imem_gnt = 1'b1;
        exp_q.push_back('{pc: addr, data: data});
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL wait_req: imem_req=%b, expected 0", imem_req);
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_valid: instr_valid=%b, expected 1", instr_valid);
        end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: instr_valid=1 with no expected entry");
        end else begin
            e = exp_q.pop_front();
            if (instr !== e.data || instr_pc !== e.pc) begin
                failures++;
                $display("FAIL hold_data: instr=%h pc=%h, expected instr=%h pc=%h", instr, instr_pc, e.data, e.pc);
            end
        end
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL accept: instr_valid=%b req=%b, expected 0/1", instr_valid, imem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_sel = 2'b00; branch_target = '0; jump_target = '0; trap_vector = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h, expected all 0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        fetch_one(32'h0, 32'h0000_0013);
        fetch_one(32'h4, 32'h0000_0013);
    endtask

    task automatic test_gnt_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL gnt_stall[%0d]: req=%b addr=%h valid=%b, expected 1/00000008/0",
                         i, imem_req, imem_addr, instr_valid);
            end
        end
        fetch_one(32'h8, 32'h0010_0093);
    endtask

    task automatic test_branch_in_wait();
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        pc_sel = 2'b01;
        branch_target = 32'h0000_0103;
        @(negedge clk);
        pc_sel = 2'b00;
        checks++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL branch_wait_addr: addr=%h req=%b, expected 00000100/0", imem_addr, imem_req);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL branch_discard: valid=%b req=%b addr=%h, expected 0/1/00000100",
                     instr_valid, imem_req, imem_addr);
        end
        fetch_one(32'h100, 32'h0000_0113);
    endtask

    task automatic test_trap_with_rvalid();
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        pc_sel      = 2'b11;
        trap_vector = 32'h0000_0080;
        @(negedge clk);
        imem_rvalid = 1'b0;
        pc_sel      = 2'b00;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            failures++;
            $display("FAIL trap_discard: valid=%b req=%b addr=%h, expected 0/1/00000080",
                     instr_valid, imem_req, imem_addr);
        end
        fetch_one(32'h80, 32'h0000_0213);
    endtask

    task automatic test_hold_stall();
        exp_t e;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h84) begin
            failures++;
            $display("FAIL hold_stall_addr: addr=%h, expected 00000084", imem_addr);
        end
        imem_gnt = 1'b1;
        exp_q.push_back('{pc: 32'h84, data: 32'h1234_5678});
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                failures++;
                $display("FAIL hold_stable[%0d]: valid=%b instr=%h pc=%h, expected 1/%h/%h",
                         i, instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        pc_sel      = 2'b10;
        jump_target = 32'h0000_0200;
        id_ready    = 1'b1;
        @(negedge clk);
        pc_sel   = 2'b00;
        id_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL jump_flush: valid=%b req=%b addr=%h, expected 0/1/00000200",
                     instr_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        pc_sel        = 2'b01;
        branch_target = 32'hFFFF_FFFE;
        @(negedge clk);
        pc_sel = 2'b00;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL redirect_in_req: req=%b addr=%h, expected 1/fffffffc", imem_req, imem_addr);
        end
        fetch_one(32'hFFFF_FFFC, 32'h0000_0073);
        fetch_one(32'h0000_0000, 32'h0000_0013);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h pc=%h, expected all 0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL late_rvalid: valid=%b req=%b addr=%h, expected 0/1/00000000",
                     instr_valid, imem_req, imem_addr);
        end
        fetch_one(32'h0, 32'h0000_0013);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_gnt_stall();
        test_branch_in_wait();
        test_trap_with_rvalid();
        test_hold_stall();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage at the front of the core's pipeline.
- Holds the PC and selects the next PC from four sources: sequential, branch, jump, trap. The 2-bit select uses the same encoding as the team's 4-input mux.
- Fetches one instruction at a time over a req/gnt/rvalid instruction-memory interface.
- Presents the instruction and its PC to decode with a valid/ready handshake.

Parameters:
- WIDTH, 32, address/data width in bits.
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; one clock; asynchronous assertion, logic leaves reset on first clk edge after release.
- pc_sel  input  2  next-PC select: 00 sequential/no redirect, 01 branch_target, 10 jump_target, 11 trap_vector.
- branch_target  input  WIDTH  branch redirect address.
- jump_target  input  WIDTH  jump redirect address.
- trap_vector  input  WIDTH  trap handler address.
- imem_req  output  1  fetch request.
- imem_addr  output  WIDTH  fetch address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  WIDTH  fetched instruction.
- instr_valid  output  1  instr/instr_pc valid to decode.
- instr  output  WIDTH  fetched instruction.
- instr_pc  output  WIDTH  address of instr.
- id_ready  input  1  decode accepts instruction.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_VECTOR, state=IDLE, kill=0.
  - imem_req=0, imem_addr=RESET_VECTOR.
  - instr_valid=0, instr=0, instr_pc=0.
- Redirect: active when pc_sel!=00. Target is selected per pc_sel and has bits[1:0] forced to 00. pc<=target on that edge.
- PC arithmetic: sequential pc+4 modulo 2^WIDTH; 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- imem_addr = pc in all states. imem_req = (state==REQ).
- At most one request outstanding. imem_addr is stable while imem_req=1 and gnt=0, unless a redirect occurs.
- State transitions:
  - IDLE -> REQ unconditionally on the next edge. pc_sel is ignored in IDLE.
  - REQ, gnt=0:
    - redirect: pc<=target, stay REQ; the new address is presented next cycle.
    - no redirect: stay REQ.
  - REQ, gnt=1:
    - no redirect: -> WAIT.
    - with redirect: pc<=target, kill<=1, -> WAIT; the in-flight response is discarded.
  - WAIT, rvalid=0:
    - redirect: pc<=target, kill<=1, stay WAIT.
    - no redirect: stay WAIT.
  - WAIT, rvalid=1:
    - kill=1 or redirect this cycle: discard data, kill<=0, pc<=target if redirecting, -> REQ.
    - otherwise: instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, -> HOLD.
  - HOLD:
    - instr, instr_pc and instr_valid stay stable until the handshake completes.
    - redirect (priority over id_ready): instr_valid<=0, pc<=target, -> REQ. Decode treats a redirect cycle as a flush; instr_valid&id_ready in that cycle is not a transfer.
    - id_ready=1, no redirect: instr_valid<=0, -> REQ.
- instr_valid is registered and is 1 only in HOLD.
- Latency: with gnt in the first REQ cycle and rvalid one cycle later, instr_valid rises 2 cycles after imem_req first rises. Steady-state throughput is 1 instruction per 3 cycles.
- Reset mid-operation: all state returns to reset values immediately. Any late rvalid arriving in IDLE/REQ is ignored.
- gnt or rvalid outside REQ/WAIT respectively is ignored.

Test Plan:
- Reset release, gnt=1 immediately, rvalid next cycle with rdata=0x00000013, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses with instr_pc 0x0, 0x4; instr=0x13.
- Hold gnt=0 for 5 cycles in REQ -> imem_req=1 and imem_addr=0x0 stable all 5 cycles; no instr_valid.
- In WAIT, pc_sel=01, branch_target=0x103 before rvalid -> response at 0x4 discarded (instr_valid stays 0); next request imem_addr=0x100.
- pc_sel=11, trap_vector=0x80, in the same cycle as rvalid -> data discarded; next imem_addr=0x80, state REQ.
- HOLD with id_ready=0 for 4 cycles -> instr and instr_pc stable, instr_valid=1. Then pc_sel=10, jump_target=0x200 with id_ready=1 -> instr_valid 0 next cycle; next imem_addr=0x200.
- Redirect to 0xFFFF_FFFC, then fetch and accept -> following imem_addr=0x0000_0000 (wrap). Assert rst_n=0 in WAIT -> outputs return to reset values asynchronously.
